// File: rtl/serial_pkg.sv
// serial_pkg: shared types and helpers for the serial link transmitter and receiver
package serial_pkg;
   typedef enum logic {IDLE, SHIFT} state_t;
   localparam int DEFAULT_WIDTH = 8;
   function automatic int clog2(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 32; i++) if ((1 << i) < n) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/s2p_shift_reg.sv
// s2p_shift_reg: frame assembly register with indexed bit writes and restart load
module s2p_shift_reg import serial_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CW = clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             load_bit0,
   input  logic             we,
   input  logic [CW-1:0]    idx,
   input  logic             d,
   output logic [WIDTH-1:0] q
);
   // restart loads bit 0 and zeroes the rest so stale bits never linger
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) q <= '0;
      else if (clr) q <= '0;
      else if (load_bit0) q <= WIDTH'(d);
      else if (we) q[idx] <= d;
endmodule

// File: rtl/serial2parallel.sv
// serial2parallel: LSB-first framed serial receiver with valid/ready word output
module serial2parallel import serial_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             d,
   input  logic             serial_start,
   input  logic             serial_end,
   output logic [WIDTH-1:0] p_data,
   output logic             p_valid,
   input  logic             p_ready,
   output logic             frame_err,
   output logic             overrun
);
   localparam int CW = clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [WIDTH-1:0] q, word;
   logic clr, ld0, we, done, err, accept, drop;

   s2p_shift_reg #(.WIDTH(WIDTH), .CW(CW)) u_sr (
      .clk(clk), .rst_n(rst_n), .clr(clr), .load_bit0(ld0), .we(we),
      .idx(cnt), .d(d), .q(q)
   );

   // framing decisions: start, bit placement, completion and violations
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      clr = 1'b0;
      ld0 = 1'b0;
      we = 1'b0;
      done = 1'b0;
      err = 1'b0;
      if (state == IDLE) begin
         if (serial_start && !serial_end) begin
            ld0 = 1'b1;
            cnt_n = CW'(1);
            state_n = SHIFT;
         end else if (serial_end) err = 1'b1;
      end else if (serial_start) begin
         err = 1'b1;
         ld0 = 1'b1;
         cnt_n = CW'(1);
      end else if (cnt == LAST || serial_end) begin
         done = (cnt == LAST) && serial_end;
         err = !done;
         clr = 1'b1;
         cnt_n = '0;
         state_n = IDLE;
      end else begin
         we = 1'b1;
         cnt_n = cnt + CW'(1);
      end
   end

   // the final bit is taken straight from d so the word is ready on the end cycle
   always_comb begin
      word = q;
      word[WIDTH-1] = d;
   end

   assign accept = done && (!p_valid || p_ready);
   assign drop = done && p_valid && !p_ready;

   // framing state and bit counter
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
      end

   // output word holding register, handshake and one-cycle status pulses
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         p_data <= '0;
         p_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun <= 1'b0;
      end else begin
         frame_err <= err;
         overrun <= drop;
         p_valid <= accept || (p_valid && !p_ready);
         if (accept) p_data <= word;
      end
endmodule

// File: tb/tb_serial2parallel.sv
// tb_serial2parallel: scoreboard bench with directed and randomized frames
module tb_serial2parallel;
   localparam int W = 8;
   logic clk = 1'b0, rst_n = 1'b0, d = 1'b0, serial_start = 1'b0, serial_end = 1'b0, p_ready = 1'b1;
   logic [W-1:0] p_data;
   logic p_valid, frame_err, overrun;
   int checks = 0, errors = 0, exp_ferr = 0, seen_ferr = 0, exp_ovr = 0, seen_ovr = 0;
   logic [W-1:0] exp_q[$];

   serial2parallel #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .d(d), .serial_start(serial_start), .serial_end(serial_end),
      .p_data(p_data), .p_valid(p_valid), .p_ready(p_ready), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // monitor: every presented word must match the scoreboard head; pop on handshake
   always @(negedge clk) if (rst_n) begin
      if (frame_err) seen_ferr++;
      if (overrun) seen_ovr++;
      if (p_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mon_unexpected: p_valid with data %0h, required no word", p_data);
         end else begin
            if (p_data !== exp_q[0]) begin
               errors++;
               $display("FAIL mon_data: got %0h required %0h", p_data, exp_q[0]);
            end
            if (p_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic bit_cyc(input logic b, input logic s, input logic e);
      d = b;
      serial_start = s;
      serial_end = e;
      @(posedge clk);
      #1;
      d = 1'b0;
      serial_start = 1'b0;
      serial_end = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) bit_cyc(1'($urandom), 1'b0, 1'b0);
   endtask

   task automatic partial(input logic [W-1:0] w, input int n, input int end_at);
      for (int i = 0; i < n; i++) bit_cyc(w[i], i == 0, i == end_at);
   endtask

   task automatic send_good(input logic [W-1:0] w, input bit push);
      partial(w, W, W - 1);
      if (push) exp_q.push_back(w);
   endtask

   task automatic checkpoint(input string tag);
      idle(2);
      chk({tag, "_frame_err_count"}, seen_ferr, exp_ferr);
      chk({tag, "_overrun_count"}, seen_ovr, exp_ovr);
   endtask

   initial begin
      int kind, k;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_p_data", p_data, 0);
      chk("reset_p_valid", p_valid, 0);
      chk("reset_frame_err", frame_err, 0);
      chk("reset_overrun", overrun, 0);
      rst_n = 1'b1;
      idle(2);
      // nominal
      send_good(8'hD3, 1);
      chk("nom_valid", p_valid, 1);
      chk("nom_data", p_data, 8'hD3);
      checkpoint("nominal");
      // back-to-back
      send_good(8'hD3, 1);
      send_good(8'h5A, 1);
      chk("b2b_data", p_data, 8'h5A);
      checkpoint("b2b");
      // backpressure and overrun
      p_ready = 1'b0;
      send_good(8'hD3, 1);
      send_good(8'h0F, 0);
      exp_ovr++;
      idle(1);
      chk("bp_overrun", seen_ovr, exp_ovr);
      chk("bp_valid", p_valid, 1);
      chk("bp_data", p_data, 8'hD3);
      p_ready = 1'b1;
      idle(1);
      chk("bp_valid_drop", p_valid, 0);
      checkpoint("backpressure");
      // early end on bit 5
      partial(8'hFF, 5, 4);
      exp_ferr++;
      idle(1);
      chk("early_valid", p_valid, 0);
      checkpoint("early_end");
      // missing end, then clean frame
      partial(8'h77, W, -1);
      exp_ferr++;
      send_good(8'hA5, 1);
      checkpoint("missing_end");
      // restart at bit 3
      partial(8'hE7, 3, -1);
      exp_ferr++;
      send_good(8'h3C, 1);
      chk("restart_data", p_data, 8'h3C);
      checkpoint("restart");
      // reset mid-frame
      partial(8'hFF, 4, -1);
      rst_n = 1'b0;
      #2;
      chk("midrst_p_data", p_data, 0);
      chk("midrst_p_valid", p_valid, 0);
      chk("midrst_frame_err", frame_err, 0);
      chk("midrst_overrun", overrun, 0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      send_good(8'h81, 1);
      chk("midrst_after_data", p_data, 8'h81);
      checkpoint("mid_reset");
      // randomized frame mix
      for (int f = 0; f < 40; f++) begin
         kind = $urandom_range(0, 4);
         case (kind)
            0: send_good(W'($urandom), 1);
            1: begin
               k = $urandom_range(0, W - 2);
               partial(W'($urandom), k + 1, k);
               exp_ferr++;
            end
            2: begin
               partial(W'($urandom), W, -1);
               exp_ferr++;
            end
            3: begin
               partial(W'($urandom), $urandom_range(1, W - 1), -1);
               exp_ferr++;
               send_good(W'($urandom), 1);
            end
            default: begin
               bit_cyc(1'($urandom), 1'b0, 1'b1);
               exp_ferr++;
            end
         endcase
         idle($urandom_range(0, 2));
      end
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
      chk("drain_queue_empty", exp_q.size(), 0);
      checkpoint("random");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/serial2parallel.md
Name: serial2parallel

Overview:
- Receiver for the team's 1-bit serial framing: `d` carries data, `serial_start` marks the first bit and `serial_end` marks the last bit.
- Bits arrive one per clock, LSB first; the block deserialises them into a WIDTH-bit word.
- The word is presented on a valid/ready parallel interface.
- Checks framing and flags errors and overruns; sits at the far end of the link from the parallel-to-serial transmitter.

Parameters:
- WIDTH, 8, bits per frame and width of `p_data`; legal range 2..32.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- d  input  1  serial data bit, sampled every clock.
- serial_start  input  1  high on the clock carrying bit 0 of a frame.
- serial_end  input  1  high on the clock carrying bit WIDTH-1 of a frame.
- p_data  output  WIDTH  received word, bit i = i-th serial bit received.
- p_valid  output  1  `p_data` holds an unconsumed word.
- p_ready  input  1  consumer accepts word when `p_valid && p_ready`.
- frame_err  output  1  one-cycle pulse on a framing violation.
- overrun  output  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Reset (async, `rst_n`=0): state IDLE, bit counter 0, shift register 0, `p_data`=0, `p_valid`=0, `frame_err`=0, `overrun`=0. Deassertion is synchronous to `clk`, and the block is usable on the next edge.
- FSM states: IDLE and SHIFT.
- IDLE:
  - `serial_start`=1 → load `d` into bit 0, count=1, go to SHIFT.
  - `serial_end`=1 without `serial_start` → `frame_err` pulse, stay IDLE.
  - Otherwise ignore `d`.
- SHIFT: each clock write `d` into bit[count], then count+1.
  - On the bit where count==WIDTH-1 with `serial_end`=1 → frame complete, go to IDLE.
  - On that bit with `serial_end`=0 → `frame_err`, discard, go to IDLE.
  - `serial_end`=1 while count<WIDTH-1 → `frame_err`, discard, go to IDLE.
  - `serial_start`=1 while in SHIFT → `frame_err` for the aborted frame; restart with this `d` as bit 0, count=1, stay in SHIFT.
- Frame complete:
  - If the output is free (`p_valid`=0), or is being consumed this cycle (`p_valid && p_ready`), then on the next edge `p_data` = assembled word and `p_valid`=1.
  - Latency: `p_valid` rises on the edge after the `serial_end` bit is sampled.
  - Otherwise (`p_valid`=1, `p_ready`=0): the new word is dropped, the old word is held, and `overrun` pulses for one cycle.
- Output handshake:
  - `p_valid` stays high and `p_data` stays stable until a `p_valid && p_ready` edge.
  - If no new word is loaded on that edge, `p_valid` falls.
  - `p_ready` while `p_valid`=0 has no effect.
- WIDTH=2 special case: `serial_start` and `serial_end` on consecutive cycles is a legal frame.
- `serial_start` and `serial_end` together in IDLE is a `frame_err` (single-bit frame illegal), and nothing is captured.
- The shift register is never exposed directly; partial frames never reach `p_data`.
- Mid-frame reset: all state is cleared, the partial frame is lost, and no error is flagged.

Decomposition:
- Package `serial_pkg`: state enum {IDLE, SHIFT}, default WIDTH constant, and a counter-width function clog2(WIDTH).
- The transmitter shares the same package.
- One sub-module, `s2p_shift_reg`: WIDTH-bit register with indexed bit load, clear, and a `load_bit0` restart input.
- FSM, counter, output register and handshake live in the top level.

Test Plan:
- Nominal: after reset, send 0xD3 as LSB-first bits 1,1,0,0,1,0,1,1 with `serial_start` on the first bit and `serial_end` on the eighth, `p_ready`=1 → `p_valid` pulses one cycle after the 8th bit, `p_data`=8'hD3, no `frame_err`/`overrun`.
- Back-to-back: 0xD3 immediately followed by 0x5A (new `serial_start` the cycle after `serial_end`), `p_ready`=1 → two consecutive `p_valid` cycles with 8'hD3 then 8'h5A.
- Backpressure/overrun: `p_ready`=0, send 0xD3 then 0x0F → `p_data` stays 8'hD3 with `p_valid`=1, `overrun` pulses once after the 0x0F frame; raising `p_ready` yields 0xD3 and `p_valid` drops.
- Framing errors:
  - `serial_end` on bit 5 → `frame_err` pulse, `p_valid` stays 0.
  - No `serial_end` on bit 8 → `frame_err`, then a clean 0xA5 frame is received correctly.
- Restart: `serial_start` reasserted at bit 3 of a frame, followed by a full 0x3C frame → one `frame_err` pulse, `p_data`=8'h3C.
- Reset mid-frame: `rst_n` low after bit 4 of 0xFF, then send 0x81 → no `p_valid` for the aborted frame, all outputs 0 during reset, `p_data`=8'h81 afterwards.
